// File: rtl/ast_packet_arbiter.sv
// Round-robin whole-packet arbiter: N_SRC Avalon-ST sinks onto one source stream.
// Each output beat carries the granting source index on src_channel.
module ast_packet_arbiter #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int N_SRC     = 4,
  parameter int CHANNEL_W = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [N_SRC*DATA_W-1:0]  snk_data,
  input  logic [N_SRC-1:0]         snk_startofpacket,
  input  logic [N_SRC-1:0]         snk_endofpacket,
  input  logic [N_SRC-1:0]         snk_valid,
  input  logic [N_SRC*EMPTY_W-1:0] snk_empty,
  output logic [N_SRC-1:0]         snk_ready,
  output logic [DATA_W-1:0]        src_data,
  output logic                     src_startofpacket,
  output logic                     src_endofpacket,
  output logic                     src_valid,
  output logic [EMPTY_W-1:0]       src_empty,
  output logic [CHANNEL_W-1:0]     src_channel,
  input  logic                     src_ready,
  output logic                     busy,
  output logic [CHANNEL_W-1:0]     grant_idx,
  output logic                     pkt_err
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_grant, r_last_grant, w_win;
  logic             r_first, r_pkt_err;
  logic             w_any, w_xfer, w_err;

  // First valid source strictly after the last winner; descending scan so the
  // nearest candidate is the one left standing.
  always_comb begin
    w_win = r_last_grant;
    w_any = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      if (snk_valid[IDX_W'((int'(r_last_grant) + k) % N_SRC)]) begin
        w_win = IDX_W'((int'(r_last_grant) + k) % N_SRC);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_next            = r_state;
    w_xfer            = 1'b0;
    w_err             = 1'b0;
    snk_ready         = '0;
    src_valid         = 1'b0;
    src_data          = snk_data[int'(r_grant)*DATA_W +: DATA_W];
    src_empty         = snk_empty[int'(r_grant)*EMPTY_W +: EMPTY_W];
    src_startofpacket = snk_startofpacket[r_grant];
    src_endofpacket   = snk_endofpacket[r_grant];
    src_channel       = CHANNEL_W'(r_grant);
    case (r_state)
      IDLE: if (w_any) w_next = BUSY;
      BUSY: begin
        // srst gating keeps handshakes dead during the reset cycle itself
        if (!srst) begin
          src_valid          = snk_valid[r_grant];
          snk_ready[r_grant] = src_ready;
        end
        w_xfer = src_valid && src_ready;
        if (w_xfer) begin
          // sop must appear on exactly the first beat of a grant
          w_err = r_first ^ src_startofpacket;
          if (src_endofpacket) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state      <= IDLE;
      r_last_grant <= IDX_W'(N_SRC - 1);
      r_grant      <= '0;
      r_first      <= 1'b0;
      r_pkt_err    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pkt_err <= w_err;
      if (r_state == IDLE && w_any) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
        r_first      <= 1'b1;
      end else if (w_xfer) begin
        r_first <= 1'b0;
      end
    end
  end

  assign busy      = (r_state == BUSY);
  assign grant_idx = CHANNEL_W'(r_grant);
  assign pkt_err   = r_pkt_err;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Bench for ast_packet_arbiter: per-source beat queues feed the DUT, a packet-level
// model predicts every cycle's outputs, and literal checks pin order and timing.
module tb_ast_packet_arbiter;

  localparam int N = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CW = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    int            cyc;
    logic [CW-1:0] chan;
    logic [EW-1:0] emp;
  } xfer_t;

  logic            clk = 1'b0;
  logic            srst;
  logic [N*DW-1:0] snk_data;
  logic [N-1:0]    snk_startofpacket, snk_endofpacket, snk_valid, snk_ready;
  logic [N*EW-1:0] snk_empty;
  logic [DW-1:0]   src_data;
  logic            src_startofpacket, src_endofpacket, src_valid, src_ready;
  logic [EW-1:0]   src_empty;
  logic [CW-1:0]   src_channel, grant_idx;
  logic            busy, pkt_err;

  ast_packet_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .N_SRC(N), .CHANNEL_W(CW)) dut (
    .clk(clk), .srst(srst),
    .snk_data(snk_data), .snk_startofpacket(snk_startofpacket),
    .snk_endofpacket(snk_endofpacket), .snk_valid(snk_valid),
    .snk_empty(snk_empty), .snk_ready(snk_ready),
    .src_data(src_data), .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket), .src_valid(src_valid),
    .src_empty(src_empty), .src_channel(src_channel), .src_ready(src_ready),
    .busy(busy), .grant_idx(grant_idx), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  beat_t    q[N][$];
  xfer_t    xlog[$];
  logic     busy_hist[0:4095];
  int       total = 0, bad = 0;
  int       cyc = 0, t0 = 0, errcnt = 0, errcyc = -1;

  // model: who owns the output, round-robin pointer, registered outputs
  int       m_owner = -1, m_ptr = N - 1, m_grant = 0;
  bit       m_first = 0, m_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        snk_data[i*DW +: DW]  = q[i][0].data;
        snk_startofpacket[i]  = q[i][0].sop;
        snk_endofpacket[i]    = q[i][0].eop;
        snk_empty[i*EW +: EW] = q[i][0].empty;
        snk_valid[i]          = 1'b1;
      end else begin
        snk_data[i*DW +: DW]  = '0;
        snk_startofpacket[i]  = 1'b0;
        snk_endofpacket[i]    = 1'b0;
        snk_empty[i*EW +: EW] = '0;
        snk_valid[i]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] v, exp_rdy;
    logic         exp_v, nerr;
    beat_t        b;
    xfer_t        x;
    drive();
    @(negedge clk);
    v       = snk_valid;
    exp_v   = !srst && (m_owner >= 0) && v[m_owner];
    exp_rdy = (!srst && m_owner >= 0) ? (N'(src_ready) << m_owner) : '0;
    chk("busy", busy, m_owner >= 0);
    chk("grant_idx", grant_idx, m_grant);
    chk("pkt_err", pkt_err, m_err);
    chk("src_valid", src_valid, exp_v);
    chk("snk_ready", snk_ready, exp_rdy);
    if (exp_v) begin
      b = q[m_owner][0];
      chk("src_data", src_data, b.data);
      chk("src_sop", src_startofpacket, b.sop);
      chk("src_eop", src_endofpacket, b.eop);
      chk("src_empty", src_empty, b.empty);
      chk("src_channel", src_channel, m_owner);
    end
    busy_hist[cyc] = busy;
    if (pkt_err) begin errcnt++; errcyc = cyc; end
    // advance model by the rules of the arbiter
    if (srst) begin
      m_owner = -1; m_ptr = N - 1; m_grant = 0; m_err = 0; m_first = 0;
    end else begin
      nerr = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (v[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N; m_ptr = m_owner; m_grant = m_owner; m_first = 1;
            break;
          end
        end
      end else if (exp_v && src_ready) begin
        b = q[m_owner].pop_front();
        x.src = m_owner; x.data = src_data; x.cyc = cyc; x.chan = src_channel; x.emp = src_empty;
        xlog.push_back(x);
        if (m_first != b.sop) nerr = 1;
        m_first = 0;
        if (b.eop) m_owner = -1;
      end
      m_err = nerr;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(int s, logic [DW-1:0] d, logic sop, logic eop, logic [EW-1:0] e);
    beat_t b;
    b.data = d; b.sop = sop; b.eop = eop; b.empty = e;
    q[s].push_back(b);
  endtask

  task automatic pushpkt(int s, int n, logic [DW-1:0] base, logic [EW-1:0] e);
    for (int k = 0; k < n; k++)
      push(s, base + DW'(k), k == 0, k == n - 1, (k == n - 1) ? e : '0);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic run(int maxc);
    int n = 0;
    while ((pending() || m_owner >= 0) && n < maxc) begin step(); n++; end
    if (pending() || m_owner >= 0) chk("timeout", 1, 0);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step();
    srst = 1'b0;
    xlog.delete();
    errcnt = 0; errcyc = -1;
    t0 = cyc;
  endtask

  task automatic chk_order(string nm, int exp[]);
    chk({nm, "_len"}, xlog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < xlog.size(); i++)
      chk(nm, xlog[i].src, exp[i]);
  endtask

  initial begin
    srst = 1'b1; src_ready = 1'b1;
    drive();
    repeat (2) step();

    // reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_err", pkt_err, 0);
    chk("rst_valid", src_valid, 0);
    chk("rst_ready", snk_ready, 0);

    // single source, 3 beats
    push(1, 64'hA, 1, 0, 0); push(1, 64'hB, 0, 0, 0); push(1, 64'hC, 0, 1, 5);
    run(20);
    chk_order("t1_order", '{1, 1, 1});
    chk("t1_first_cyc", xlog[0].cyc - t0, 1);
    chk("t1_last_cyc", xlog[2].cyc - t0, 3);
    chk("t1_last_data", xlog[2].data, 64'hC);
    chk("t1_chan", xlog[2].chan, 1);
    chk("t1_empty", xlog[2].emp, 5);
    chk("t1_busy_eop", busy_hist[t0 + 3], 1);
    chk("t1_busy_drop", busy_hist[t0 + 4], 0);

    // contention 0,2,3
    do_reset();
    pushpkt(0, 2, 64'h100, 0); pushpkt(2, 2, 64'h200, 0); pushpkt(3, 2, 64'h300, 0);
    run(40);
    chk_order("t2_order", '{0, 0, 2, 2, 3, 3});
    chk("t2_gap_a", xlog[2].cyc - xlog[1].cyc, 2);
    chk("t2_gap_b", xlog[4].cyc - xlog[3].cyc, 2);

    // re-request on source 0
    do_reset();
    pushpkt(0, 2, 64'h10, 0); pushpkt(0, 2, 64'h20, 0); pushpkt(1, 2, 64'h30, 0);
    run(40);
    chk_order("t3_order", '{0, 0, 1, 1, 0, 0});
    chk("t3_last_data", xlog[5].data, 64'h21);

    // backpressure on a 4-beat packet from source 2
    do_reset();
    pushpkt(2, 4, 64'h40, 2);
    step();
    src_ready = 1'b1; step();
    src_ready = 1'b0; step();
    src_ready = 1'b0; step();
    src_ready = 1'b1; step();
    run(20);
    chk_order("t4_order", '{2, 2, 2, 2});
    chk("t4_b1_cyc", xlog[1].cyc - t0, 4);
    for (int i = 0; i < 4 && i < xlog.size(); i++) chk("t4_data", xlog[i].data, 64'h40 + i);

    // reset in the middle of a 5-beat packet from source 3
    do_reset();
    pushpkt(3, 5, 64'h300, 0);
    repeat (3) step();
    chk("t5_pre_beats", xlog.size(), 2);
    srst = 1'b1;
    pushpkt(0, 2, 64'h400, 0);
    step();
    srst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_valid", src_valid, 0);
    run(40);
    chk_order("t5_order", '{3, 3, 0, 0, 3, 3, 3});
    if (xlog.size() == 7) chk("t5_resume", xlog[4].data, 64'h302);

    // protocol error: missing sop on source 1, clean single beat on source 2
    do_reset();
    push(1, 64'h500, 0, 0, 0); push(1, 64'h501, 0, 0, 0); push(1, 64'h502, 0, 1, 1);
    push(2, 64'h600, 1, 1, 3);
    run(30);
    chk_order("t6_order", '{1, 1, 1, 2});
    chk("t6_errcnt", errcnt, 1);
    chk("t6_errcyc", errcyc, xlog[0].cyc + 1);
    if (xlog.size() == 4) begin
      chk("t6_d0", xlog[0].data, 64'h500);
      chk("t6_d3", xlog[3].data, 64'h600);
      chk("t6_e3", xlog[3].emp, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ast_packet_arbiter.md
Name: ast_packet_arbiter

Overview:
- N_SRC-input Avalon-ST packet arbiter that shares one downstream stream sink, typically the width extender input, between several packet sources.
- Grants whole packets in round-robin order and never interleaves beats of different packets.
- Tags every output beat with the granting source index on src_channel.
- Sits directly in front of the width extender. Its src_* side connects to the extender's snk_* side.

Parameters:
- DATA_W, 64, data bus width per source and on output
- EMPTY_W, 3, empty field width; must be at least $clog2(DATA_W/8)
- N_SRC, 4, number of requesting sources, 2..16
- CHANNEL_W, 4, output channel width; must be at least $clog2(N_SRC)

Ports:
- clk  in  1  clock
- srst  in  1  synchronous active-high reset
- snk_data  in  N_SRC*DATA_W  packed source data, source i at [i*DATA_W +: DATA_W]
- snk_startofpacket  in  N_SRC  per-source sop
- snk_endofpacket  in  N_SRC  per-source eop
- snk_valid  in  N_SRC  per-source valid
- snk_empty  in  N_SRC*EMPTY_W  packed per-source empty
- snk_ready  out  N_SRC  per-source ready
- src_data  out  DATA_W  granted data
- src_startofpacket  out  1  granted sop
- src_endofpacket  out  1  granted eop
- src_valid  out  1  granted valid
- src_empty  out  EMPTY_W  granted empty
- src_channel  out  CHANNEL_W  granted source index, zero-extended
- src_ready  in  1  downstream ready
- busy  out  1  high while a packet is granted
- grant_idx  out  CHANNEL_W  current or last grant index
- pkt_err  out  1  one-cycle pulse on a protocol error

Behaviour:
- One clock. srst is synchronous and active-high.
- On srst:
  - state goes to IDLE.
  - Round-robin pointer last_grant resets to N_SRC-1, so source 0 has highest priority first.
  - grant_idx, busy and pkt_err reset to 0.
  - src_valid and all snk_ready bits are 0 during reset and in the cycle after.
- srst mid-packet abandons the packet with no flush. The source's remaining beats are later arbitrated as a new request.
- IDLE state:
  - snk_ready is all 0 and src_valid is 0.
  - If any snk_valid bit is set, the winner is the first set index strictly after last_grant, scanning upward with wrap modulo N_SRC.
  - Next cycle: grant_idx = winner, last_grant = winner, busy = 1, state BUSY.
  - If no source is valid, state stays IDLE.
- BUSY state, combinational mux on grant g:
  - src_data, src_empty, src_startofpacket, src_endofpacket and src_valid are taken from source g.
  - src_channel = g.
  - snk_ready[g] = src_ready; all other snk_ready bits are 0.
  - src_valid is never qualified by src_ready, so it is Avalon-ST compliant with ready latency 0.
- Beat transfer: a beat transfers when src_valid && src_ready. Only transfers advance state.
- End of packet: on a transfer with src_endofpacket = 1, state goes to IDLE and busy drops next cycle. This gives one arbitration bubble between packets, and that bubble is required.
- Single-beat packets (sop and eop on the same beat) are legal: a 1-cycle BUSY with a transfer, then IDLE.
- Missing sop error:
  - Condition: the first transferred beat after a grant has sop = 0.
  - pkt_err pulses 1 on the cycle after the transfer.
  - The beat is still forwarded, and the packet continues until eop.
- Unexpected sop error:
  - Condition: a transfer with sop = 1 that is not the first beat of the grant.
  - pkt_err pulses, and the beat is forwarded.
- Input channel fields are not used. src_channel is always driven from the grant.
- Valid dropped mid-packet: if source g drops snk_valid mid-packet, the grant is held and src_valid = 0. There is no timeout.
- Fairness: a source that wins cannot win again while any other source was valid at the arbitration cycle.
- Width and combinational-path rules:
  - grant_idx is zero-extended to CHANNEL_W.
  - There is a combinational path src_ready -> snk_ready, and none from snk_valid to snk_ready.

Test Plan:
- Single source: source 1 sends a 3-beat packet (0xA,0xB,0xC, eop empty=5), src_ready=1 -> grant at cycle 1. src_channel=1 and src_empty=5 on the last beat. busy drops one cycle after eop.
- Contention: sources 0, 2 and 3 each hold a 2-beat packet pending from reset -> output order 0,2,3. Exactly one idle cycle between packets, and no interleaved beats.
- Round robin with re-request: source 0 has two back-to-back packets and source 1 has one, all valid at reset -> output order 0,1,0.
- Backpressure: src_ready toggles 1,0,0,1 during a 4-beat packet from source 2 -> snk_ready[2] mirrors src_ready exactly. Data is held while stalled, all 4 beats are delivered once, and other snk_ready bits stay 0.
- Reset mid-packet: srst is asserted after beat 2 of 5 from source 3 -> next cycle src_valid=0 and busy=0. After release, source 0 (valid) wins before source 3.
- Protocol error: source 1 first beat has sop=0, and a single-beat packet on source 2 has sop=eop=1 -> pkt_err is one pulse for source 1 only. Both packets are forwarded intact.
